cordic_mul_pipe_sat: RTL and testbench

Parametrised, pipelined signed multiplier for the CORDIC datapath. It is the successor to the single-cycle combinational DSP48 multiply.
- Adds configurable pipeline depth, valid/ready flow control, post-multiply scaling with optional rounding, and saturation.
- Reports overflow per output beat and keeps a saturating overflow event counter.
- Sits between the CORDIC gain/iteration stages and downstream fixed-point consumers.

---
 rtl/cordic_mul_pipe_sat_if.sv | 30 +++
 rtl/cordic_mul_pipe_sat.sv | 129 ++++++++++++
 tb/tb_cordic_mul_pipe_sat.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_mul_pipe_sat_if.sv
// Operand/result bus for cordic_mul_pipe_sat.
//   master : operand source and result consumer (drives in_valid, din0, din1, out_ready, ovf_clr)
//   slave  : the multiplier (drives in_ready, out_valid, dout, dout_ovf, ovf_cnt)
interface cordic_mul_pipe_sat_if #(
  parameter int unsigned A_W   = 13,
  parameter int unsigned B_W   = 12,
  parameter int unsigned OUT_W = 22,
  parameter int unsigned CNT_W = 16
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   din0;
  logic signed [B_W-1:0]   din1;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_ovf;
  logic [CNT_W-1:0]        ovf_cnt;
  logic                    ovf_clr;

  modport master (
    output in_valid, din0, din1, out_ready, ovf_clr,
    input  in_ready, out_valid, dout, dout_ovf, ovf_cnt
  );

  modport slave (
    input  in_valid, din0, din1, out_ready, ovf_clr,
    output in_ready, out_valid, dout, dout_ovf, ovf_cnt
  );
endinterface

// File: rtl/cordic_mul_pipe_sat.sv
// Pipelined signed multiplier with post-multiply scaling, optional round-half-up,
// saturation or wrap, per-beat overflow flag and a saturating overflow event counter.
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   bus       cordic_mul_pipe_sat_if.slave: in_valid/in_ready/din0/din1 operand beat,
//             out_valid/out_ready/dout/dout_ovf result beat, ovf_cnt/ovf_clr counter
// Stage 1 multiplies, stages 2..NUM_STAGE-1 are plain delays (retiming slack for the DSP),
// the last stage rounds, shifts and range-limits. With NUM_STAGE=1 everything is one stage.
module cordic_mul_pipe_sat #(
  parameter int unsigned A_W       = 13,
  parameter int unsigned B_W       = 12,
  parameter int unsigned OUT_W     = 22,
  parameter int unsigned SHIFT     = 3,
  parameter int unsigned ROUND     = 1,
  parameter int unsigned SAT       = 1,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned CNT_W     = 16
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  cordic_mul_pipe_sat_if.slave bus
);

  localparam int unsigned P_W  = A_W + B_W;
  // Result width: one guard bit above the product so the rounding add cannot wrap,
  // widened further if the output is wider than that.
  localparam int unsigned RW   = (P_W + 1 > OUT_W) ? P_W + 1 : OUT_W;
  localparam int          NDLY = int'(NUM_STAGE) - 1;
  localparam int unsigned RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ({{(RW-1){1'b0}}, 1'b1} << RSH) : '0;
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = ~MAXV;
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic adv;
  logic out_valid_q;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic ovf_q, ovf;
  logic [CNT_W-1:0] cnt_q;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  logic signed [P_W-1:0] a_ext, b_ext, prod;
  assign a_ext = P_W'(bus.din0);
  assign b_ext = P_W'(bus.din1);
  assign prod  = a_ext * b_ext;

  // Product and valid entering the final scaling stage.
  logic signed [P_W-1:0] pre_p;
  logic                  pre_v;

  if (NUM_STAGE == 1) begin : g_direct
    assign pre_p = prod;
    assign pre_v = bus.in_valid;
  end else begin : g_dly
    logic signed [P_W-1:0] p_q [NDLY];
    logic                  v_q [NDLY];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int i = 0; i < NDLY; i++) begin
          p_q[i] <= '0;
          v_q[i] <= 1'b0;
        end
      end else if (adv) begin
        p_q[0] <= prod;
        v_q[0] <= bus.in_valid;
        for (int i = 1; i < NDLY; i++) begin
          p_q[i] <= p_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign pre_p = p_q[NDLY-1];
    assign pre_v = v_q[NDLY-1];
  end

  logic signed [RW-1:0] sum, r;

  always_comb begin
    sum    = $signed({{(RW-P_W){pre_p[P_W-1]}}, pre_p}) + RND;
    r      = sum >>> SHIFT;
    ovf    = (r > MAXV) || (r < MINV);
    dout_d = r[OUT_W-1:0];
    if (SAT != 0) begin
      if (r > MAXV) begin
        dout_d = OMAX;
      end else if (r < MINV) begin
        dout_d = OMIN;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= pre_v;
      dout_q      <= dout_d;
      ovf_q       <= ovf & pre_v;
    end
  end

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (bus.ovf_clr) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && ovf_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_ovf  = ovf_q;
  assign bus.ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_cordic_mul_pipe_sat.sv
// Bench for cordic_mul_pipe_sat: four builds driven by the same operand stream,
// expected results queued at input acceptance and compared when each beat leaves.
//   u0: SHIFT=3 ROUND=1 SAT=1 CNT_W=16   u1: SHIFT=3 ROUND=0 SAT=1 CNT_W=16
//   u2: SHIFT=0 SAT=1 CNT_W=4            u3: SHIFT=0 SAT=0 CNT_W=16
module tb_cordic_mul_pipe_sat;
  localparam int NS = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ovf_clr = 1'b0;
  logic [12:0] din0 = '0;
  logic [11:0] din1 = '0;

  always #5 ap_clk = ~ap_clk;

  cordic_mul_pipe_sat_if #(.A_W(13), .B_W(12), .OUT_W(22), .CNT_W(16)) v0 ();
  cordic_mul_pipe_sat_if #(.A_W(13), .B_W(12), .OUT_W(22), .CNT_W(16)) v1 ();
  cordic_mul_pipe_sat_if #(.A_W(13), .B_W(12), .OUT_W(22), .CNT_W(4))  v2 ();
  cordic_mul_pipe_sat_if #(.A_W(13), .B_W(12), .OUT_W(22), .CNT_W(16)) v3 ();

  assign v0.in_valid = in_valid;  assign v1.in_valid = in_valid;
  assign v2.in_valid = in_valid;  assign v3.in_valid = in_valid;
  assign v0.din0 = din0;  assign v1.din0 = din0;  assign v2.din0 = din0;  assign v3.din0 = din0;
  assign v0.din1 = din1;  assign v1.din1 = din1;  assign v2.din1 = din1;  assign v3.din1 = din1;
  assign v0.out_ready = out_ready;  assign v1.out_ready = out_ready;
  assign v2.out_ready = out_ready;  assign v3.out_ready = out_ready;
  assign v0.ovf_clr = ovf_clr;  assign v1.ovf_clr = ovf_clr;
  assign v2.ovf_clr = ovf_clr;  assign v3.ovf_clr = ovf_clr;

  cordic_mul_pipe_sat #(.SHIFT(3), .ROUND(1), .SAT(1), .NUM_STAGE(NS), .CNT_W(16)) u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(v0.slave));
  cordic_mul_pipe_sat #(.SHIFT(3), .ROUND(0), .SAT(1), .NUM_STAGE(NS), .CNT_W(16)) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(v1.slave));
  cordic_mul_pipe_sat #(.SHIFT(0), .ROUND(1), .SAT(1), .NUM_STAGE(NS), .CNT_W(4)) u2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(v2.slave));
  cordic_mul_pipe_sat #(.SHIFT(0), .ROUND(1), .SAT(0), .NUM_STAGE(NS), .CNT_W(16)) u3 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(v3.slave));

  logic [21:0] dout_a [4];
  logic        ovf_a [4];
  logic        ov_a [4];
  logic        ir_a [4];
  logic [15:0] cnt_a [4];

  assign dout_a[0] = v0.dout;  assign dout_a[1] = v1.dout;
  assign dout_a[2] = v2.dout;  assign dout_a[3] = v3.dout;
  assign ovf_a[0] = v0.dout_ovf;  assign ovf_a[1] = v1.dout_ovf;
  assign ovf_a[2] = v2.dout_ovf;  assign ovf_a[3] = v3.dout_ovf;
  assign ov_a[0] = v0.out_valid;  assign ov_a[1] = v1.out_valid;
  assign ov_a[2] = v2.out_valid;  assign ov_a[3] = v3.out_valid;
  assign ir_a[0] = v0.in_ready;  assign ir_a[1] = v1.in_ready;
  assign ir_a[2] = v2.in_ready;  assign ir_a[3] = v3.in_ready;
  assign cnt_a[0] = v0.ovf_cnt;  assign cnt_a[1] = v1.ovf_cnt;
  assign cnt_a[2] = {12'b0, v2.ovf_cnt};  assign cnt_a[3] = v3.ovf_cnt;

  typedef struct {
    logic [3:0][21:0] d;
    logic [3:0]       o;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   mcnt [4] = '{0, 0, 0, 0};
  int   sh_c [4] = '{3, 3, 0, 0};
  bit   rnd_c [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit   sat_c [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int   max_c [4] = '{65535, 65535, 15, 65535};
  bit   lat_en = 1'b1;
  bit   stall_prev = 1'b0;
  bit   accepted = 1'b0;
  logic [21:0] held [4];
  int   tab_a [10] = '{100, -4096, 4095, -4096, 7, -1, 1234, -4096, 0, -2000};
  int   tab_b [10] = '{200, -2048, 2047, 2047, -9, -1, -567, -2048, 55, 1500};
  int   sent;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec arithmetic: full product, optional round-half-up, arithmetic shift, range limit.
  function automatic logic [22:0] model(input int a, input int b, input int sh,
                                        input bit rnd, input bit sat);
    longint p, r;
    logic [63:0] ru;
    logic ovf;
    logic [21:0] d;
    p = longint'(a) * longint'(b);
    if (rnd && sh > 0) p = p + (longint'(1) << (sh - 1));
    r = p >>> sh;
    ovf = (r > 2097151) || (r < -2097152);
    ru = r;
    if (sat && r > 2097151) d = 22'h1FFFFF;
    else if (sat && r < -2097152) d = 22'h200000;
    else d = ru[21:0];
    return {ovf, d};
  endfunction

  // One clock: observe at the falling edge, update the model, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    logic [22:0] m;
    @(negedge ap_clk);
    for (int i = 0; i < 4; i++) begin
      chk("in_ready", ir_a[i], out_ready || !ov_a[0]);
      chk("ovf_cnt", cnt_a[i], mcnt[i]);
    end
    for (int i = 1; i < 4; i++) chk("valid_match", ov_a[i], ov_a[0]);
    chk("no_spurious_beat", ov_a[0] && (q.size() == 0), 0);
    if (stall_prev) begin
      chk("stall_valid", ov_a[0], 1);
      for (int i = 0; i < 4; i++) chk("stall_dout", dout_a[i], held[i]);
    end
    stall_prev = ov_a[0] && !out_ready;
    for (int i = 0; i < 4; i++) held[i] = dout_a[i];
    if (ov_a[0] && out_ready && q.size() > 0) begin
      e = q.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk("dout", dout_a[i], e.d[i]);
        chk("dout_ovf", ovf_a[i], e.o[i]);
        if (!ovf_clr && e.o[i] && mcnt[i] < max_c[i]) mcnt[i]++;
      end
      if (e.lat) chk("latency", cyc - e.acc, NS - 1);
    end
    if (ovf_clr) for (int i = 0; i < 4; i++) mcnt[i] = 0;
    accepted = in_valid && ir_a[0];
    if (accepted) begin
      for (int i = 0; i < 4; i++) begin
        m = model($signed(din0), $signed(din1), sh_c[i], rnd_c[i], sat_c[i]);
        e.d[i] = m[21:0];
        e.o[i] = m[22];
      end
      e.acc = cyc + 1;
      e.lat = lat_en;
      q.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int a, input int b);
    din0 = 13'(a);
    din1 = 12'(b);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (accepted) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", accepted, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && q.size() > 0; k++) cycle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    // Reset state
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_out_valid", ov_a[i], 0);
      chk("rst_dout", dout_a[i], 0);
      chk("rst_dout_ovf", ovf_a[i], 0);
      chk("rst_ovf_cnt", cnt_a[i], 0);
    end
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk("rst_in_ready", ir_a[i], 1);

    // Directed single beats: rounding/truncation, negative, saturation and wrap
    send(3, 5);
    drain();
    send(-3, 5);
    drain();
    send(-4096, -2048);
    drain();
    chk("cnt_after_sat", cnt_a[2], 1);
    chk("cnt_after_wrap", cnt_a[3], 1);

    // Back-to-back stream with a three-cycle output stall
    lat_en = 1'b0;
    sent = 0;
    for (int t = 0; t < 40 && sent < 10; t++) begin
      din0 = 13'(tab_a[sent]);
      din1 = 12'(tab_b[sent]);
      in_valid = 1'b1;
      out_ready = !(t >= 4 && t <= 6);
      cycle();
      if (accepted) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 10);
    drain();
    lat_en = 1'b1;

    // Clear has priority over a coincident overflow increment
    ovf_clr = 1'b1;
    send(-4096, -2048);
    drain();
    ovf_clr = 1'b0;
    cycle();
    chk("cnt_cleared", cnt_a[2], 0);

    // Counter saturation in the CNT_W=4 build
    din0 = 13'(-4096);
    din1 = 12'(-2048);
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    in_valid = 1'b0;
    drain();
    cycle();
    chk("cnt_sticky", cnt_a[2], 15);

    // Reset with beats in flight
    din0 = 13'(3);
    din1 = 12'(5);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    in_valid = 1'b0;
    ap_rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("midrst_out_valid", ov_a[i], 0);
    q.delete();
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
    stall_prev = 1'b0;
    #1;
    ap_rst_n = 1'b1;
    for (int k = 0; k < 2 * NS + 2; k++) cycle();
    chk("midrst_queue", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
